// File: rtl/load_data_fmt_pkg.sv
// Shared cache-load definitions: access size encodings used by the line
// shifter and by the load result formatter.
package load_data_fmt_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fmt_state_e;

endpackage

// File: rtl/load_data_fmt_ext.sv
// Combinational sign/zero extension and misalignment detection for one
// right-aligned load beat.
module load_ext
  import load_data_fmt_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        offset,
  input  size_e             size,
  input  logic              uns,
  output logic [DATA_W-1:0] data_fmt,
  output logic              misalign
);

  logic [DATA_W-1:0] ext;
  logic              fill;

  always_comb begin
    ext      = data;
    fill     = 1'b0;
    misalign = 1'b0;
    unique case (size)
      SZ_B: begin
        fill = ~uns & data[7];
        ext  = {{(DATA_W-8){fill}}, data[7:0]};
      end
      SZ_H: begin
        fill     = ~uns & data[15];
        ext      = {{(DATA_W-16){fill}}, data[15:0]};
        misalign = offset[0];
      end
      SZ_W: begin
        fill     = ~uns & data[31];
        ext      = {{(DATA_W-32){fill}}, data[31:0]};
        misalign = |offset[1:0];
      end
      SZ_D: begin
        ext      = data;
        misalign = |offset[2:0];
      end
      default: ext = data;
    endcase
  end

  // A faulting load must not leak any line data into the register file.
  assign data_fmt = misalign ? '0 : ext;

endmodule

// File: rtl/load_data_fmt.sv
// Load result formatter: extends/validates a beat at capture, then holds it
// in a 2-entry skid buffer (main + skid) with a registered s_ready_o.
module load_data_fmt
  import load_data_fmt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              clk_i,
  input  logic              srst_n,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [3:0]        s_offset_i,
  input  logic [1:0]        s_size_i,
  input  logic              s_unsigned_i,
  input  logic [4:0]        s_rd_i,
  input  logic [ID_W-1:0]   s_id_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [4:0]        m_rd_o,
  output logic [ID_W-1:0]   m_id_o,
  output logic              m_misalign_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        rd;
    logic [ID_W-1:0]   id;
    logic              mis;
  } ent_t;

  fmt_state_e state, state_nxt;
  ent_t       main_q, skid_q, ent_in;
  logic       acc, otx;
  logic       ld_main_in, ld_skid_in, ld_main_skid;

  load_ext #(.DATA_W(DATA_W)) u_ext (
    .data     (s_data_i),
    .offset   (s_offset_i),
    .size     (size_e'(s_size_i)),
    .uns      (s_unsigned_i),
    .data_fmt (ent_in.data),
    .misalign (ent_in.mis)
  );
  assign ent_in.rd = s_rd_i;
  assign ent_in.id = s_id_i;

  // Handshake flags decode straight from the state register only.
  assign s_ready_o = (state != ST_FULL);
  assign m_valid_o = (state != ST_EMPTY);
  assign acc       = s_valid_i & s_ready_o;
  assign otx       = m_valid_o & m_ready_i;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_skid_in   = 1'b0;
    ld_main_skid = 1'b0;
    unique case (state)
      ST_EMPTY: if (acc) begin
        state_nxt  = ST_ONE;
        ld_main_in = 1'b1;
      end
      ST_ONE: begin
        if (acc && otx)      ld_main_in = 1'b1;
        else if (acc) begin
          state_nxt  = ST_FULL;
          ld_skid_in = 1'b1;
        end else if (otx)    state_nxt  = ST_EMPTY;
      end
      ST_FULL: if (otx) begin
        state_nxt    = ST_ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_nxt    = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_skid_in   = 1'b0;
      ld_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (ld_main_in)        main_q <= ent_in;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid_in)        skid_q <= ent_in;
    end
  end

  assign m_data_o     = main_q.data;
  assign m_rd_o       = main_q.rd;
  assign m_id_o       = main_q.id;
  assign m_misalign_o = main_q.mis;

endmodule

// File: tb/tb_load_data_fmt.sv
// Directed and random-traffic checks of the load formatter and skid buffer.
module tb_load_data_fmt;

  logic        clk_i = 1'b0;
  logic        srst_n, flush_i, s_valid_i, s_ready_o, s_unsigned_i;
  logic [63:0] s_data_i, m_data_o;
  logic [3:0]  s_offset_i;
  logic [1:0]  s_size_i;
  logic [4:0]  s_rd_i, m_rd_o;
  logic [7:0]  s_id_i, m_id_o;
  logic        m_valid_o, m_ready_i, m_misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  load_data_fmt #(.DATA_W(64), .ID_W(8)) dut (
    .clk_i(clk_i), .srst_n(srst_n), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_offset_i(s_offset_i), .s_size_i(s_size_i), .s_unsigned_i(s_unsigned_i),
    .s_rd_i(s_rd_i), .s_id_i(s_id_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_rd_o(m_rd_o),
    .m_id_o(m_id_o), .m_misalign_o(m_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {misalign, data}
  function automatic logic [64:0] model(input logic [63:0] d, input logic [3:0] off,
                                        input logic [1:0] sz, input logic u);
    logic        mis;
    logic [63:0] r;
    case (sz)
      2'd0: begin mis = 1'b0;         r = u ? {56'h0, d[7:0]}  : {{56{d[7]}},  d[7:0]};  end
      2'd1: begin mis = off[0];       r = u ? {48'h0, d[15:0]} : {{48{d[15]}}, d[15:0]}; end
      2'd2: begin mis = |off[1:0];    r = u ? {32'h0, d[31:0]} : {{32{d[31]}}, d[31:0]}; end
      default: begin mis = |off[2:0]; r = d; end
    endcase
    if (mis) r = 64'h0;
    return {mis, r};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [3:0] off, input logic [1:0] sz,
                       input logic u, input logic [4:0] rd, input logic [7:0] id);
    s_valid_i = 1'b1; s_data_i = d; s_offset_i = off; s_size_i = sz;
    s_unsigned_i = u; s_rd_i = rd; s_id_i = id;
  endtask

  // Offer one beat with m_ready_i=1, check the result one cycle later, drain it.
  task automatic one_beat(input string tag, input logic [63:0] d, input logic [3:0] off,
                          input logic [1:0] sz, input logic u, input logic [4:0] rd,
                          input logic [7:0] id, input logic [63:0] exp_d, input logic exp_m);
    drive(d, off, sz, u, rd, id);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    chk({tag, "_vld"}, m_valid_o, 1'b1);
    chk({tag, "_data"}, m_data_o, exp_d);
    chk({tag, "_mis"}, m_misalign_o, exp_m);
    chk({tag, "_tag"}, {m_rd_o, m_id_o}, {rd, id});
    @(posedge clk_i); #1;
    chk({tag, "_drain"}, m_valid_o, 1'b0);
  endtask

  logic [77:0] q[$];
  logic [77:0] expv;
  logic [64:0] mres;
  logic        seen;

  initial begin
    srst_n = 1'b0; flush_i = 1'b0; m_ready_i = 1'b1;
    drive(64'hdead_beef, 4'h0, 2'd3, 1'b0, 5'd7, 8'h55);
    repeat (2) @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
    chk("rst_vld", m_valid_o, 1'b0);
    chk("rst_rdy", s_ready_o, 1'b1);
    chk("rst_out", {m_data_o, m_rd_o, m_id_o, m_misalign_o}, '0);
    srst_n = 1'b1;
    @(posedge clk_i); #1;

    one_beat("t1", 64'h80,   4'd3, 2'd0, 1'b0, 5'd1, 8'h11, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    one_beat("t2", 64'h8001, 4'd2, 2'd1, 1'b1, 5'd2, 8'h12, 64'h8001, 1'b0);
    one_beat("t3", 64'h8001, 4'd1, 2'd1, 1'b1, 5'd3, 8'h13, 64'h0, 1'b1);
    one_beat("t4", 64'h8123_4567_89AB_CDEF, 4'd8, 2'd3, 1'b0, 5'd4, 8'h14,
             64'h8123_4567_89AB_CDEF, 1'b0);
    one_beat("t4b", 64'h1234_5678_8000_1234, 4'd4, 2'd2, 1'b0, 5'd5, 8'h15,
             64'hFFFF_FFFF_8000_1234, 1'b0);
    one_beat("t4c", 64'hFFFF_FFFF_FFFF_FF7F, 4'd0, 2'd0, 1'b0, 5'd6, 8'h16, 64'h7F, 1'b0);
    one_beat("t4d", 64'hAA, 4'd4, 2'd3, 1'b0, 5'd7, 8'h17, 64'h0, 1'b1);

    // Test 5: back-pressure fills both entries, then drains in order.
    m_ready_i = 1'b0;
    drive(64'h1, 4'd0, 2'd3, 1'b0, 5'd1, 8'd1);
    @(posedge clk_i); #1;
    chk("t5_rdy1", s_ready_o, 1'b1);
    drive(64'h2, 4'd0, 2'd3, 1'b0, 5'd2, 8'd2);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    chk("t5_full", s_ready_o, 1'b0);
    chk("t5_id1", m_id_o, 8'd1);
    m_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("t5_rdy2", s_ready_o, 1'b1);
    chk("t5_id2", {m_valid_o, m_id_o}, {1'b1, 8'd2});
    @(posedge clk_i); #1;
    chk("t5_empty", m_valid_o, 1'b0);

    // Test 6: flush while FULL with a beat offered.
    m_ready_i = 1'b0;
    drive(64'h3, 4'd0, 2'd3, 1'b0, 5'd3, 8'd3);
    @(posedge clk_i); #1;
    drive(64'h4, 4'd0, 2'd3, 1'b0, 5'd4, 8'd4);
    @(posedge clk_i); #1;
    drive(64'h5, 4'd0, 2'd3, 1'b0, 5'd5, 8'd5);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1;
    chk("t6_vld", m_valid_o, 1'b0);
    chk("t6_rdy", s_ready_o, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (m_valid_o) seen = 1'b1;
    end
    chk("t6_noout", seen, 1'b0);

    // Reset with an entry held.
    m_ready_i = 1'b0;
    drive(64'h99, 4'd0, 2'd3, 1'b0, 5'd9, 8'd9);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    srst_n = 1'b0;
    @(posedge clk_i); #1;
    srst_n = 1'b1;
    chk("rst2_flags", {m_valid_o, s_ready_o}, 2'b01);
    chk("rst2_out", {m_data_o, m_rd_o, m_id_o, m_misalign_o}, '0);

    // Test 7: random traffic against scoreboard.
    begin
      int sent = 0, got = 0, cyc = 0;
      while (got < 10000 && cyc < 80000) begin
        @(posedge clk_i); #1;
        drive({$urandom, $urandom}, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        s_valid_i = (sent < 10000) && ($urandom_range(0, 3) != 0);
        m_ready_i = ($urandom_range(0, 3) != 0);
        @(negedge clk_i);
        if (s_valid_i && s_ready_o) begin
          mres = model(s_data_i, s_offset_i, s_size_i, s_unsigned_i);
          q.push_back({mres[64], s_rd_i, s_id_i, mres[63:0]});
          sent++;
        end
        if (m_valid_o && m_ready_i) begin
          if (q.size() == 0) chk("rnd_extra", 1'b1, 1'b0);
          else begin
            expv = q.pop_front();
            chk("rnd_beat", {m_misalign_o, m_rd_o, m_id_o, m_data_o}, expv);
          end
          got++;
        end
        cyc++;
      end
      chk("rnd_count", got, 10000);
      chk("rnd_left", q.size(), 0);
    end
    s_valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_data_fmt.md
LOAD_DATA_FMT -- requirements
Module: load_data_fmt

Interface
REQ-001 Parameter DATA_W, 64, result width in bits.
REQ-002 Parameter ID_W, 8, width of the load instruction tag.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 srst_n  in  1  reset; synchronous, active-low.
REQ-005 flush_i  in  1  pipeline flush; kills every held entry.
REQ-006 s_valid_i  in  1  upstream holds a right-aligned load beat.
REQ-007 s_ready_o  out  1  this block accepts a beat this cycle.
REQ-008 s_data_i  in  DATA_W  data already right-shifted by the line shifter; bits above the access size are don't-care.
REQ-009 s_offset_i  in  4  byte offset of the access within the 16-byte line.
REQ-010 s_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 s_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
REQ-012 s_rd_i  in  5  destination register index.
REQ-013 s_id_i  in  ID_W  instruction tag.
REQ-014 m_valid_o  out  1  formatted result is presented.
REQ-015 m_ready_i  in  1  downstream writeback accepts the result.
REQ-016 m_data_o  out  DATA_W  extended result.
REQ-017 m_rd_o  out  5  destination register index.
REQ-018 m_id_o  out  ID_W  instruction tag.
REQ-019 m_misalign_o  out  1  load-address-misaligned exception flag.

Function
REQ-020 A transfer occurs on either side only when valid and ready are both 1 in the same cycle.
REQ-021 Extension uses bit 7, 15, 31 of s_data_i for sizes 0, 1, 2 respectively; sign-extension uses that bit and zero-extension uses 0; size 3 passes all 64 bits unchanged.
REQ-022 Misalign is set when the offset is not a multiple of the access size: size 1 with offset[0]; size 2 with offset[1:0] nonzero; size 3 with offset[2:0] nonzero.
REQ-023 When misalign is set, m_data_o SHALL be 0 and rd/id SHALL still pass through.
REQ-024 Formatting happens at entry capture, so the output registers hold final values and m_data_o has no combinational path from s_data_i.
REQ-025 Latency is exactly 1 cycle: a beat accepted at edge N is presented with m_valid_o=1 after edge N.
REQ-026 Storage is a 2-entry skid buffer with a main register and a skid register, and output fields are always driven from the main register.
REQ-027 s_ready_o SHALL equal "skid register empty"; it is registered and has no combinational dependence on m_ready_i.
REQ-028 States are EMPTY, ONE (main full) and FULL (main and skid full).
REQ-029 EMPTY: accept -> ONE.
REQ-030 ONE: accept with no output transfer -> FULL (new beat to skid); accept with output transfer -> ONE (new beat to main); output transfer only -> EMPTY.
REQ-031 FULL: output transfer -> ONE (skid moves to main); s_ready_o=0.
REQ-032 Results SHALL leave in acceptance order with no loss and no duplication.
REQ-033 With m_ready_i held at 1, throughput is one beat per cycle.
REQ-034 flush_i=1 forces the state to EMPTY at the next edge; any beat offered in that cycle is discarded; flush has priority over every other event.
REQ-035 When m_valid_o=0, m_data_o, m_rd_o, m_id_o and m_misalign_o SHALL hold their last values; these values are not a valid result.

Reset
REQ-036 While srst_n=0 at an edge: state SHALL be EMPTY, m_valid_o=0, s_ready_o=1, m_misalign_o=0, and m_data_o, m_rd_o and m_id_o SHALL be 0.
REQ-037 Reset asserted during operation discards all held entries at that edge, with the same result as REQ-036.
REQ-038 The datapath registers SHALL reset to 0 so that simulation produces no X values.

Structure
REQ-039 Size encodings (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3) SHALL be defined in the shared cache package and used by both the line shifter and this block.
REQ-040 The extension and misalign logic SHALL be a single combinational sub-module, load_ext, which is instantiated once at the skid buffer input.

Verification
REQ-041 Test 1: data=0x80, size 0, signed, offset 3 -> one cycle later, m_data_o=0xFFFF_FFFF_FFFF_FF80 and misalign=0.
REQ-042 Test 2: data=0x8001, size 1, unsigned, offset 2 -> m_data_o=0x8001.
REQ-043 Test 3: size 1 with offset 1 -> misalign=1, m_data_o=0.
REQ-044 Test 4: size 3 with offset 8 -> misalign=0 and data unchanged.
REQ-045 Test 5: m_ready_i=0 while two beats are sent (ids 1 and 2) -> s_ready_o=0 after the second beat; then m_ready_i=1 -> ids 1 and 2 appear in order, and s_ready_o=1 one cycle after id 1 leaves.
REQ-046 Test 6: flush_i=1 in FULL while a beat is offered -> next cycle m_valid_o=0, s_ready_o=1, and no flushed id ever appears at the output.
REQ-047 Test 7: random valid/ready traffic with 10k beats -> output id sequence equals input id sequence, and every result matches a reference model of REQ-021 to REQ-023.
